// File: rtl/axi_spi_sd_s00_axi.sv
// axi_spi_sd_s00_axi
//   AXI4-Lite slave wrapping a byte-wide SPI master (mode 0) for SD cards in SPI mode.
//   Register map (word index = addr[3:2]):
//     0x0 CTRL   [0] CS level (reset 1), [1] START (write-1 pulse, reads 0)
//     0x4 DATA   write: TXDATA[7:0]; read: RXDATA[7:0]
//     0x8 CLKDIV [15:0] half-period count DIV (reset 124)
//     0xC STATUS [0] BUSY, [1] DONE (read-only)
//   Ports:
//     S_AXI_ACLK / S_AXI_ARESETN   clock, synchronous active-low reset
//     S_AXI_AW* / W* / B*          AXI4-Lite write channels
//     S_AXI_AR* / R*               AXI4-Lite read channels
//     SD_CLK, SD_MOSI, SD_MISO     SPI bus (CPOL=0, MSB first)
//     SD_CS                        card chip-select, active-low, driven from CTRL[0]
module axi_spi_sd_s00_axi #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  output logic                              SD_CLK,
  output logic                              SD_MOSI,
  input  logic                              SD_MISO,
  output logic                              SD_CS,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY
);

  typedef enum logic {S_IDLE, S_XFER} state_e;

  state_e      state_q;
  logic        awready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]  raddr_q;
  logic [31:0] rdata_q, rdata_d;
  logic        cs_q, sclk_q, mosi_q, done_q;
  logic [7:0]  txdata_q, rxdata_q, tx_shift_q, rx_shift_q;
  logic [15:0] div_q, cnt_q;
  logic [2:0]  fall_cnt_q;

  logic       wr_en, rd_en, start_req, tick, busy;
  logic [1:0] wr_idx;

  // Control fields that are never looked at; collected here so they are visibly ignored.
  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                         S_AXI_WDATA[31:16], S_AXI_WSTRB[3:2]};

  assign busy = (state_q == S_XFER);

  always_comb begin
    wr_en     = S_AXI_AWVALID & S_AXI_WVALID & ~awready_q & ~bvalid_q;
    rd_en     = S_AXI_ARVALID & ~arready_q & ~rvalid_q;
    wr_idx    = S_AXI_AWADDR[3:2];
    start_req = wr_en & (wr_idx == 2'd0) & S_AXI_WSTRB[0] & S_AXI_WDATA[1];
    tick      = (cnt_q == div_q);
    unique case (raddr_q)
      2'd0:    rdata_d = {31'b0, cs_q};
      2'd1:    rdata_d = {24'b0, rxdata_q};
      2'd2:    rdata_d = {16'b0, div_q};
      default: rdata_d = {30'b0, done_q, busy};
    endcase
  end

  // NOTE: every register here uses non-blocking assignment so all flops sample pre-edge
  // values; that is what makes a STATUS read coinciding with the BUSY fall return BUSY=1.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= S_IDLE;
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      raddr_q    <= 2'd0;
      rdata_q    <= '0;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b1;
      done_q     <= 1'b0;
      txdata_q   <= 8'hFF;
      rxdata_q   <= 8'h00;
      tx_shift_q <= 8'h00;
      rx_shift_q <= 8'h00;
      div_q      <= 16'd124;
      cnt_q      <= 16'd0;
      fall_cnt_q <= 3'd0;
    end else begin
      // Write channel: single-cycle AW/W ready pulse, response on the following cycle.
      awready_q <= wr_en;
      if (awready_q)                  bvalid_q <= 1'b1;
      else if (bvalid_q && S_AXI_BREADY) bvalid_q <= 1'b0;

      // Read channel: address latched with ARREADY, data registered with RVALID.
      arready_q <= rd_en;
      if (rd_en) raddr_q <= S_AXI_ARADDR[3:2];
      if (arready_q) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end

      if (wr_en) begin
        unique case (wr_idx)
          2'd0: if (S_AXI_WSTRB[0]) cs_q <= S_AXI_WDATA[0];
          2'd1: if (S_AXI_WSTRB[0]) txdata_q <= S_AXI_WDATA[7:0];
          2'd2: if (!busy) begin
            // The divider is frozen during a transfer so the bit timing stays consistent.
            if (S_AXI_WSTRB[0]) div_q[7:0]  <= S_AXI_WDATA[7:0];
            if (S_AXI_WSTRB[1]) div_q[15:8] <= S_AXI_WDATA[15:8];
          end
          default: ;
        endcase
      end

      unique case (state_q)
        S_IDLE: begin
          sclk_q <= 1'b0;
          mosi_q <= 1'b1;
          if (start_req) begin
            tx_shift_q <= txdata_q;
            mosi_q     <= txdata_q[7];
            done_q     <= 1'b0;
            cnt_q      <= 16'd0;
            fall_cnt_q <= 3'd0;
            state_q    <= S_XFER;
          end
        end
        S_XFER: begin
          if (tick) begin
            cnt_q  <= 16'd0;
            sclk_q <= ~sclk_q;
            if (!sclk_q) begin
              rx_shift_q <= {rx_shift_q[6:0], SD_MISO};
            end else if (fall_cnt_q == 3'd7) begin
              // Eighth falling edge: byte complete, bus back to idle levels.
              rxdata_q <= rx_shift_q;
              done_q   <= 1'b1;
              mosi_q   <= 1'b1;
              state_q  <= S_IDLE;
            end else begin
              fall_cnt_q <= fall_cnt_q + 3'd1;
              tx_shift_q <= {tx_shift_q[6:0], 1'b0};
              mosi_q     <= tx_shift_q[6];
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign SD_CLK        = sclk_q;
  assign SD_MOSI       = mosi_q;
  assign SD_CS         = cs_q;

endmodule

// File: tb/tb_axi_spi_sd_s00_axi.sv
// Testbench for axi_spi_sd_s00_axi: AXI4-Lite register traffic plus an SD-card
// MISO responder, checked cycle by cycle against a timing/register model.
module tb_axi_spi_sd_s00_axi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sd_clk, sd_mosi, sd_cs;
  logic        sd_miso = 1'b1;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [31:0] wdata = '0, rdata;
  logic [3:0]  wstrb = '0;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  axi_spi_sd_s00_axi dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .SD_CLK(sd_clk), .SD_MOSI(sd_mosi), .SD_MISO(sd_miso), .SD_CS(sd_cs),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  int cyc = 0;  // number of rising clock edges so far
  always @(posedge clk) cyc++;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: register contents plus the edge window of the current transfer.
  logic        m_cs;
  logic [7:0]  m_tx, m_rx, m_card, m_xtx;
  logic [15:0] m_div, m_xdiv;
  int          m_start, m_end;
  logic        mon_on = 1'b0;
  int          mon_e;
  logic [7:0]  card = 8'h00;
  int          bit_idx = 0;

  function automatic void model_reset();
    m_cs = 1'b1; m_tx = 8'hFF; m_rx = 8'h00; m_card = 8'h00;
    m_div = 16'd124; m_start = 0; m_end = -1;
  endfunction

  // State after rising edge c.
  function automatic logic busy_at(input int c);
    return (c >= m_start) && (c < m_end);
  endfunction
  function automatic logic done_at(input int c);
    return (m_end >= 0) && (c >= m_end);
  endfunction

  function automatic logic [31:0] exp_read(input logic [1:0] idx, input int c);
    logic [31:0] r;
    r = '0;
    case (idx)
      2'd0:    r = {31'b0, m_cs};
      2'd1:    r = {24'b0, (done_at(c) ? m_card : m_rx)};
      2'd2:    r = {16'b0, m_div};
      default: r = {30'b0, done_at(c), busy_at(c)};
    endcase
    return r;
  endfunction

  // Apply a write accepted on rising edge e.
  function automatic void apply_write(input logic [1:0] idx, input logic [31:0] d,
                                      input logic [3:0] s, input int e);
    logic was_busy;
    was_busy = busy_at(e - 1);
    case (idx)
      2'd0: if (s[0]) begin
        m_cs = d[0];
        if (d[1] && !was_busy) begin
          if (m_end >= 0) m_rx = m_card;
          m_card  = card;
          m_xtx   = m_tx;
          m_xdiv  = m_div;
          m_start = e;
          m_end   = e + 16 * (int'(m_div) + 1);
          mon_e   = e;
          mon_on  = 1'b1;
        end
      end
      2'd1: if (s[0]) m_tx = d[7:0];
      2'd2: if (!was_busy) begin
        if (s[0]) m_div[7:0]  = d[7:0];
        if (s[1]) m_div[15:8] = d[15:8];
      end
      default: ;
    endcase
  endfunction

  // SD card responder: next bit shifted out on each falling SD_CLK.
  always @(negedge sd_clk) begin
    bit_idx++;
    if (bit_idx < 8) sd_miso = card[7-bit_idx];
    else             sd_miso = 1'b1;
  end

  task automatic prep_card(input logic [7:0] c);
    card = c; bit_idx = 0; sd_miso = c[7];
  endtask

  // Bus monitor: SD_CLK phase p = t/(DIV+1); odd phases high, MOSI carries bit 7-p/2.
  always @(negedge clk) begin
    int t, p, len;
    if (mon_on) begin
      t = cyc - mon_e;
      len = 16 * (int'(m_xdiv) + 1);
      if (t >= len) begin
        check("sclk_idle_after_xfer", {31'b0, sd_clk}, 32'd0);
        check("mosi_idle_after_xfer", {31'b0, sd_mosi}, 32'd1);
        mon_on = 1'b0;
      end else begin
        p = t / (int'(m_xdiv) + 1);
        check("sclk_phase", {31'b0, sd_clk}, p % 2);
        check("mosi_bit", {31'b0, sd_mosi}, {31'b0, m_xtx[7 - p/2]});
      end
    end
  end

  // Both AXI tasks start and end on a falling clock edge.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] d,
                           input logic [3:0] s, input int hold);
    int e;
    logic got;
    got = 1'b0;
    if (hold > 0) bready = 1'b0;
    awaddr = addr; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awready) begin got = 1'b1; break; end
    end
    check("aw_handshake", {31'b0, got}, 32'd1);
    e = cyc;
    check("wready_pulse", {31'b0, wready}, 32'd1);
    awvalid = 1'b0; wvalid = 1'b0;
    if (got) apply_write(addr[3:2], d, s, e);
    check("sd_cs", {31'b0, sd_cs}, {31'b0, m_cs});
    @(negedge clk);
    check("bvalid_rise", {31'b0, bvalid}, 32'd1);
    check("awready_single", {31'b0, awready}, 32'd0);
    check("bresp", {30'b0, bresp}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bvalid_hold", {31'b0, bvalid}, 32'd1);
    end
    bready = 1'b1;
    @(negedge clk);
    check("bvalid_clear", {31'b0, bvalid}, 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] addr, input string tag);
    int a;
    logic got;
    got = 1'b0;
    araddr = addr; arvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arready) begin got = 1'b1; break; end
    end
    check("ar_handshake", {31'b0, got}, 32'd1);
    a = cyc;
    arvalid = 1'b0;
    @(negedge clk);
    check("rvalid_rise", {31'b0, rvalid}, 32'd1);
    check("rresp", {30'b0, rresp}, 32'd0);
    check(tag, rdata, exp_read(addr[3:2], a));
    @(negedge clk);
    check("rvalid_clear", {31'b0, rvalid}, 32'd0);
  endtask

  task automatic wait_xfer();
    for (int i = 0; i < 6000 && mon_on; i++) @(negedge clk);
    check("xfer_complete", {31'b0, mon_on}, 32'd0);
    mon_on = 1'b0;
  endtask

  // Read STATUS so that ARREADY lands one edge before BUSY falls.
  task automatic read_status_at_fall();
    for (int i = 0; i < 6000 && cyc < m_end - 2; i++) @(negedge clk);
    check("fall_read_window", {31'b0, (cyc == m_end - 2)}, 32'd1);
    axi_read(4'hC, "status_at_busy_fall");
  endtask

  task automatic transfer(input logic [15:0] d, input logic [7:0] tx, input logic [7:0] c);
    axi_write(4'h8, {16'h0, d}, 4'hF, 0);
    axi_write(4'h4, {24'h0, tx}, 4'hF, 0);
    prep_card(c);
    axi_write(4'h0, 32'h2, 4'hF, 0);
  endtask

  initial begin
    logic [7:0]  tx, c, tx2;
    logic [15:0] d;
    model_reset();

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_sd_cs", {31'b0, sd_cs}, 32'd1);
    check("rst_sd_clk", {31'b0, sd_clk}, 32'd0);
    check("rst_sd_mosi", {31'b0, sd_mosi}, 32'd1);
    check("rst_bvalid", {31'b0, bvalid}, 32'd0);
    check("rst_rvalid", {31'b0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    axi_read(4'h8, "rst_clkdiv");
    check("rst_clkdiv_const", rdata, 32'h7C);
    axi_read(4'hC, "rst_status");
    axi_read(4'h4, "rst_rxdata");
    axi_read(4'h0, "rst_ctrl");

    // Aliased CTRL write with all ones: CS stays high, START fires.
    axi_write(4'h8, 32'h1, 4'hF, 0);
    prep_card(8'h96);
    axi_write(4'h1, 32'hFFFF_FFFF, 4'hF, 0);
    wait_xfer();
    axi_read(4'h4, "rx_after_alias");
    prep_card(8'h5A);
    axi_write(4'h0, 32'h2, 4'hF, 0);
    check("cs_low", {31'b0, sd_cs}, 32'd0);
    axi_read(4'hC, "status_busy");
    wait_xfer();

    // DIV=0, TX=0xA5, card returns 0x3C.
    transfer(16'd0, 8'hA5, 8'h3C);
    read_status_at_fall();
    wait_xfer();
    axi_read(4'h4, "rx_3c");
    check("rx_3c_const", rdata, 32'h3C);
    axi_read(4'hC, "status_done");

    // DIV=3: 4-cycle half periods, 64-cycle transfer.
    transfer(16'd3, 8'($urandom), 8'($urandom));
    read_status_at_fall();
    wait_xfer();
    axi_read(4'h4, "rx_div3");

    // Writes during a transfer: START/CLKDIV ignored, TXDATA and CS take effect.
    tx2 = 8'($urandom);
    transfer(16'd5, 8'($urandom), 8'($urandom));
    axi_write(4'h0, 32'h2, 4'hF, 0);
    axi_write(4'h8, 32'h9, 4'hF, 0);
    axi_write(4'h4, {24'h0, tx2}, 4'hF, 0);
    axi_write(4'h0, 32'h3, 4'hF, 0);
    axi_write(4'h0, 32'h2, 4'hF, 0);
    wait_xfer();
    axi_read(4'h8, "clkdiv_unchanged");
    axi_read(4'h4, "rx_busy_writes");
    prep_card(8'($urandom));
    axi_write(4'h0, 32'h2, 4'hF, 0);
    wait_xfer();
    axi_read(4'h4, "rx_tx2_xfer");

    // BVALID held under back-pressure, then reset mid-transfer.
    transfer(16'd3, 8'($urandom), 8'($urandom));
    axi_write(4'h4, 32'h11, 4'hF, 4);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    mon_on = 1'b0;
    model_reset();
    @(negedge clk);
    check("abort_sd_clk", {31'b0, sd_clk}, 32'd0);
    check("abort_sd_mosi", {31'b0, sd_mosi}, 32'd1);
    check("abort_sd_cs", {31'b0, sd_cs}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    axi_read(4'hC, "abort_status");
    axi_read(4'h8, "abort_clkdiv");
    axi_read(4'h4, "abort_rxdata");

    // Randomized transfers with partial strobes.
    for (int k = 0; k < 6; k++) begin
      d  = 16'($urandom_range(0, 4));
      tx = 8'($urandom);
      c  = 8'($urandom);
      axi_write(4'h8, {16'hFFFF, 8'hFF, d[7:0]}, 4'b0001, 0);
      axi_write(4'h4, {24'($urandom), tx}, 4'b0001, 0);
      prep_card(c);
      axi_write(4'h0, 32'h2, 4'hF, 0);
      if (k % 2 == 0) read_status_at_fall();
      wait_xfer();
      axi_read(4'h4, "rand_rx");
      axi_read(4'hC, "rand_status");
      axi_read(4'h8, "rand_clkdiv");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
